// File: rtl/csr_trap_seq.sv
// CSR/trap sequencer: turns CSRRW/RS/RC, ECALL and MRET requests into a series
// of single-port accesses to an external machine-mode CSR file.
module csr_trap_seq #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [2:0]            req_op,
  input  logic [ADDR_WIDTH-1:0] req_csr,
  input  logic [DATA_WIDTH-1:0] req_src,
  input  logic [DATA_WIDTH-1:0] req_pc,
  input  logic [DATA_WIDTH-1:0] req_cause,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_redirect,
  output logic [DATA_WIDTH-1:0] rsp_npc,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] csr_addr,
  output logic [DATA_WIDTH-1:0] csr_wdata,
  output logic                  csr_wen,
  input  logic [DATA_WIDTH-1:0] csr_rdata,
  output logic [3:0]            dbg_state
);

  // Handshakes: a transfer happens on a posedge where valid && ready are both 1;
  // once accepted, request fields are latched, and a response stays stable
  // until it is consumed.

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_RMW     = 4'd1,
    S_T_EPC   = 4'd2,
    S_T_CAUSE = 4'd3,
    S_T_STAT  = 4'd4,
    S_T_VEC   = 4'd5,
    S_R_STAT  = 4'd6,
    S_R_EPC   = 4'd7,
    S_RESP    = 4'd8
  } state_t;

  localparam logic [2:0] OP_RW   = 3'd0;
  localparam logic [2:0] OP_RS   = 3'd1;
  localparam logic [2:0] OP_RC   = 3'd2;
  localparam logic [2:0] OP_CALL = 3'd3;
  localparam logic [2:0] OP_MRET = 3'd4;

  localparam logic [ADDR_WIDTH-1:0] A_MSTATUS = ADDR_WIDTH'(12'h300);
  localparam logic [ADDR_WIDTH-1:0] A_MTVEC   = ADDR_WIDTH'(12'h305);
  localparam logic [ADDR_WIDTH-1:0] A_MEPC    = ADDR_WIDTH'(12'h341);
  localparam logic [ADDR_WIDTH-1:0] A_MCAUSE  = ADDR_WIDTH'(12'h342);

  state_t                state_q, state_d;
  logic [2:0]            op_q;
  logic [ADDR_WIDTH-1:0] csr_q;
  logic [DATA_WIDTH-1:0] src_q;
  logic [DATA_WIDTH-1:0] pc_q;
  logic [DATA_WIDTH-1:0] cause_q;
  logic                  rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic                  rsp_redirect_q;
  logic [DATA_WIDTH-1:0] rsp_npc_q;
  logic                  rsp_err_q;
  logic [DATA_WIDTH-1:0] stat_trap_d;
  logic [DATA_WIDTH-1:0] stat_ret_d;

  // mstatus on trap entry: MPIE<=MIE, MIE<=0, MPP<=M; on return the reverse.
  always_comb begin
    stat_trap_d        = csr_rdata;
    stat_trap_d[7]     = csr_rdata[3];
    stat_trap_d[3]     = 1'b0;
    stat_trap_d[12:11] = 2'b11;
    stat_ret_d         = csr_rdata;
    stat_ret_d[3]      = csr_rdata[7];
    stat_ret_d[7]      = 1'b1;
    stat_ret_d[12:11]  = 2'b00;
  end

  always_comb begin
    state_d   = state_q;
    csr_addr  = '0;
    csr_wdata = '0;
    csr_wen   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          case (req_op)
            OP_RW, OP_RS, OP_RC: state_d = S_RMW;
            OP_CALL:             state_d = S_T_EPC;
            OP_MRET:             state_d = S_R_STAT;
            default:             state_d = S_RESP;
          endcase
        end
      end
      S_RMW: begin
        csr_addr = csr_q;
        case (op_q)
          OP_RW:   csr_wdata = src_q;
          OP_RS:   csr_wdata = csr_rdata | src_q;
          default: csr_wdata = csr_rdata & ~src_q;
        endcase
        // Set/clear with a zero mask must not write (read-only CSRs stay legal).
        csr_wen = (op_q == OP_RW) || (src_q != '0);
        state_d = S_RESP;
      end
      S_T_EPC: begin
        csr_addr  = A_MEPC;
        csr_wdata = pc_q;
        csr_wen   = 1'b1;
        state_d   = S_T_CAUSE;
      end
      S_T_CAUSE: begin
        csr_addr  = A_MCAUSE;
        csr_wdata = cause_q;
        csr_wen   = 1'b1;
        state_d   = S_T_STAT;
      end
      S_T_STAT: begin
        csr_addr  = A_MSTATUS;
        csr_wdata = stat_trap_d;
        csr_wen   = 1'b1;
        state_d   = S_T_VEC;
      end
      S_T_VEC: begin
        csr_addr = A_MTVEC;
        state_d  = S_RESP;
      end
      S_R_STAT: begin
        csr_addr  = A_MSTATUS;
        csr_wdata = stat_ret_d;
        csr_wen   = 1'b1;
        state_d   = S_R_EPC;
      end
      S_R_EPC: begin
        csr_addr = A_MEPC;
        state_d  = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      op_q           <= '0;
      csr_q          <= '0;
      src_q          <= '0;
      pc_q           <= '0;
      cause_q        <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_rdata_q    <= '0;
      rsp_redirect_q <= 1'b0;
      rsp_npc_q      <= '0;
      rsp_err_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= (state_d == S_RESP);
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            op_q      <= req_op;
            csr_q     <= req_csr;
            src_q     <= req_src;
            pc_q      <= req_pc;
            cause_q   <= req_cause;
            rsp_err_q <= (req_op > OP_MRET);
          end
        end
        S_RMW: rsp_rdata_q <= csr_rdata;
        S_T_VEC: begin
          rsp_npc_q      <= csr_rdata & ~DATA_WIDTH'(3);
          rsp_redirect_q <= 1'b1;
        end
        S_R_EPC: begin
          rsp_npc_q      <= csr_rdata;
          rsp_redirect_q <= 1'b1;
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_rdata_q    <= '0;
            rsp_npc_q      <= '0;
            rsp_redirect_q <= 1'b0;
            rsp_err_q      <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // rst_n gates req_ready so it reads 0 for the whole reset window.
  assign req_ready    = rst_n && (state_q == S_IDLE);
  assign rsp_valid    = rsp_valid_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign rsp_redirect = rsp_redirect_q;
  assign rsp_npc      = rsp_npc_q;
  assign rsp_err      = rsp_err_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_csr_trap_seq.sv
// Self-checking bench for csr_trap_seq: a behavioural CSR file, a reference
// model of each request's effect, and directed plus random scenarios.
module tb_csr_trap_seq;
  localparam int AW = 12;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [2:0]    req_op = '0;
  logic [AW-1:0] req_csr = '0;
  logic [DW-1:0] req_src = '0;
  logic [DW-1:0] req_pc = '0;
  logic [DW-1:0] req_cause = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_redirect;
  logic [DW-1:0] rsp_npc;
  logic          rsp_err;
  logic [AW-1:0] csr_addr;
  logic [DW-1:0] csr_wdata;
  logic          csr_wen;
  logic [DW-1:0] csr_rdata;
  logic [3:0]    dbg_state;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0]    csr_mem [0:4095];
  logic [DW-1:0]    m_csr   [0:4095];
  logic [AW+DW-1:0] exp_q[$];
  logic [AW+DW-1:0] obs_q[$];
  logic [AW-1:0]    csr_list [6] = '{12'h300, 12'h305, 12'h341, 12'h342, 12'h340, 12'h7c0};

  always #5 clk = ~clk;

  csr_trap_seq #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_csr(req_csr), .req_src(req_src), .req_pc(req_pc), .req_cause(req_cause),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_redirect(rsp_redirect), .rsp_npc(rsp_npc), .rsp_err(rsp_err),
    .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_wen(csr_wen),
    .csr_rdata(csr_rdata), .dbg_state(dbg_state)
  );

  // CSR file environment: combinational read, write lands at posedge.
  assign csr_rdata = csr_mem[csr_addr];
  always @(posedge clk) if (csr_wen) csr_mem[csr_addr] <= csr_wdata;
  always @(negedge clk) if (rst_n && csr_wen) obs_q.push_back({csr_addr, csr_wdata});

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_csr(input logic [AW-1:0] a, input logic [DW-1:0] v);
    csr_mem[a] = v;
    m_csr[a]   = v;
  endtask

  // Reference model: architectural effect of one request.
  task automatic model_txn(input logic [2:0] op, input logic [AW-1:0] a,
                           input logic [DW-1:0] src, input logic [DW-1:0] pc,
                           input logic [DW-1:0] cause, output int lat,
                           output logic [DW-1:0] e_rdata, output logic [DW-1:0] e_npc,
                           output logic e_redir, output logic e_err);
    logic [DW-1:0] old, nw, ms;
    e_rdata = '0; e_npc = '0; e_redir = 1'b0; e_err = 1'b0;
    case (op)
      3'd0, 3'd1, 3'd2: begin
        lat = 2;
        old = m_csr[a];
        e_rdata = old;
        if (op == 3'd0) nw = src;
        else if (op == 3'd1) nw = old | src;
        else nw = old & ~src;
        if (op == 3'd0 || src != 0) begin
          m_csr[a] = nw;
          exp_q.push_back({a, nw});
        end
      end
      3'd3: begin
        lat = 5;
        ms = m_csr[12'h300];
        m_csr[12'h341] = pc;    exp_q.push_back({12'h341, pc});
        m_csr[12'h342] = cause; exp_q.push_back({12'h342, cause});
        nw = (ms & ~32'h1888) | (ms[3] ? 32'h80 : 32'h0) | 32'h1800;
        m_csr[12'h300] = nw;    exp_q.push_back({12'h300, nw});
        e_npc = m_csr[12'h305] & ~32'h3;
        e_redir = 1'b1;
      end
      3'd4: begin
        lat = 3;
        ms = m_csr[12'h300];
        nw = (ms & ~32'h1888) | (ms[7] ? 32'h8 : 32'h0) | 32'h80;
        m_csr[12'h300] = nw;    exp_q.push_back({12'h300, nw});
        e_npc = m_csr[12'h341];
        e_redir = 1'b1;
      end
      default: begin
        lat = 1;
        e_err = 1'b1;
      end
    endcase
  endtask

  // Drives one request, follows it through to the response handshake.
  task automatic run_txn(input logic [2:0] op, input logic [AW-1:0] a,
                         input logic [DW-1:0] src, input logic [DW-1:0] pc,
                         input logic [DW-1:0] cause, input int hold, input string tag,
                         output int exp_lat, output time acc_t);
    int lat, to;
    logic [DW-1:0] e_rdata, e_npc;
    logic e_redir, e_err, bad;
    model_txn(op, a, src, pc, cause, exp_lat, e_rdata, e_npc, e_redir, e_err);
    rsp_ready = (hold == 0);
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_csr = a; req_src = src; req_pc = pc; req_cause = cause;
    to = 0;
    while (!req_ready && to < 50) begin @(negedge clk); to++; end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL %s accept: req_ready=%b required 1", tag, req_ready);
    end
    @(posedge clk);
    acc_t = $time;
    #1;
    req_valid = 1'b0;
    req_op = 3'($urandom); req_csr = AW'($urandom); req_src = $urandom;
    req_pc = $urandom; req_cause = $urandom;
    lat = 1;
    @(negedge clk);
    while (!rsp_valid && lat < 20) begin lat++; @(negedge clk); end
    checks++;
    if (lat != exp_lat) begin
      errors++; $display("FAIL %s latency: got %0d required %0d", tag, lat, exp_lat);
    end
    for (int i = 0; i <= hold; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== e_rdata || rsp_npc !== e_npc ||
          rsp_redirect !== e_redir || rsp_err !== e_err) begin
        errors++;
        $display("FAIL %s rsp[%0d]: v=%b rdata=%h npc=%h redir=%b err=%b required 1 %h %h %b %b",
                 tag, i, rsp_valid, rsp_rdata, rsp_npc, rsp_redirect, rsp_err,
                 e_rdata, e_npc, e_redir, e_err);
      end
      checks++;
      if (req_ready !== 1'b0 || csr_wen !== 1'b0 || csr_addr !== '0 || csr_wdata !== '0) begin
        errors++;
        $display("FAIL %s idle_port[%0d]: req_ready=%b wen=%b addr=%h wdata=%h required all 0",
                 tag, i, req_ready, csr_wen, csr_addr, csr_wdata);
      end
      if (i < hold) @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== '0 || rsp_npc !== '0 || rsp_redirect !== 1'b0 ||
        rsp_err !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s after_hs: v=%b rdata=%h npc=%h redir=%b err=%b rdy=%b required 0 0 0 0 0 1",
               tag, rsp_valid, rsp_rdata, rsp_npc, rsp_redirect, rsp_err, req_ready);
    end
    bad = (obs_q.size() != exp_q.size());
    if (!bad) foreach (exp_q[k]) if (obs_q[k] !== exp_q[k]) bad = 1'b1;
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL %s writes: got %0d writes (first %h) required %0d (first %h)", tag,
               obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : '0,
               exp_q.size(), (exp_q.size() > 0) ? exp_q[0] : '0);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4096; i++) set_csr(12'(i), '0);
    #3;
    checks++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_rdata !== '0 || rsp_npc !== '0 ||
        rsp_redirect !== 1'b0 || rsp_err !== 1'b0 || csr_wen !== 1'b0 || csr_addr !== '0 ||
        csr_wdata !== '0) begin
      errors++;
      $display("FAIL reset_outputs: rdy=%b v=%b wen=%b addr=%h required all 0",
               req_ready, rsp_valid, csr_wen, csr_addr);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release: req_ready=%b required 1", req_ready);
    end
  endtask

  task automatic test_directed();
    int l; time t;
    set_csr(12'h300, 32'h0);
    run_txn(3'd1, 12'h300, 32'h8, 0, 0, 0, "csrrs_mstatus", l, t);
    checks++;
    if (csr_mem[12'h300] !== 32'h8) begin
      errors++; $display("FAIL csrrs_value: mstatus=%h required 00000008", csr_mem[12'h300]);
    end
    set_csr(12'h305, 32'h80000101);
    run_txn(3'd2, 12'h305, 32'h0, 0, 0, 1, "csrrc_zero", l, t);
    set_csr(12'h300, 32'h8);
    run_txn(3'd3, 12'h000, 32'h0, 32'h80000010, 32'd11, 0, "ecall", l, t);
    checks++;
    if (csr_mem[12'h300] !== 32'h1880 || csr_mem[12'h341] !== 32'h80000010 ||
        csr_mem[12'h342] !== 32'd11) begin
      errors++;
      $display("FAIL ecall_state: mstatus=%h mepc=%h mcause=%h required 00001880 80000010 0000000b",
               csr_mem[12'h300], csr_mem[12'h341], csr_mem[12'h342]);
    end
    set_csr(12'h341, 32'h80000014);
    run_txn(3'd4, 12'h000, 32'h0, 0, 0, 0, "mret", l, t);
    checks++;
    if (csr_mem[12'h300] !== 32'h88) begin
      errors++; $display("FAIL mret_state: mstatus=%h required 00000088", csr_mem[12'h300]);
    end
  endtask

  task automatic test_stall_and_illegal();
    int l; time t;
    set_csr(12'h340, 32'hcafe0000);
    run_txn(3'd0, 12'h340, 32'h12345678, 0, 0, 4, "stall_rw", l, t);
    run_txn(3'd6, 12'h300, 32'hffffffff, 0, 0, 0, "illegal_6", l, t);
    run_txn(3'd5, 12'h341, 32'h1, 0, 0, 2, "illegal_5", l, t);
    run_txn(3'd7, 12'h342, 32'h1, 0, 0, 0, "illegal_7", l, t);
  endtask

  task automatic test_back_to_back();
    int l, prev_l; time t, prev_t;
    prev_l = 0; prev_t = 0;
    for (int i = 0; i < 16; i++) begin
      run_txn(3'($urandom_range(0, 7)), csr_list[$urandom_range(0, 5)], $urandom,
              $urandom, $urandom, 0, "b2b", l, t);
      if (i > 0) begin
        checks++;
        if (t - prev_t != time'((prev_l + 1) * 10)) begin
          errors++;
          $display("FAIL b2b_spacing: gap=%0t required %0d", t - prev_t, (prev_l + 1) * 10);
        end
      end
      prev_l = l; prev_t = t;
    end
  endtask

  task automatic test_random();
    int l; time t;
    logic [DW-1:0] src;
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 4) == 0) set_csr(12'h305, $urandom);
      if ($urandom_range(0, 4) == 0) set_csr(12'h300, $urandom);
      src = ($urandom_range(0, 3) == 0) ? '0 : $urandom;
      run_txn(3'($urandom_range(0, 7)), csr_list[$urandom_range(0, 5)], src,
              $urandom, $urandom, $urandom_range(0, 3), "random", l, t);
    end
  endtask

  task automatic test_reset_abort();
    int l; time t;
    set_csr(12'h300, 32'h8);
    set_csr(12'h341, 32'h0);
    set_csr(12'h342, 32'hdead0001);
    rsp_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'd3; req_pc = 32'h00001234; req_cause = 32'd5;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || csr_wen !== 1'b0 || csr_addr !== '0 ||
        csr_wdata !== '0 || rsp_redirect !== 1'b0 || rsp_npc !== '0) begin
      errors++;
      $display("FAIL abort_outputs: rdy=%b v=%b wen=%b addr=%h wdata=%h required all 0",
               req_ready, rsp_valid, csr_wen, csr_addr, csr_wdata);
    end
    @(negedge clk);
    checks++;
    if (csr_mem[12'h341] !== 32'h1234 || csr_mem[12'h342] !== 32'hdead0001 ||
        csr_mem[12'h300] !== 32'h8) begin
      errors++;
      $display("FAIL abort_state: mepc=%h mcause=%h mstatus=%h required 00001234 dead0001 00000008",
               csr_mem[12'h341], csr_mem[12'h342], csr_mem[12'h300]);
    end
    checks++;
    if (obs_q.size() != 1 || obs_q[0] !== {12'h341, 32'h1234}) begin
      errors++; $display("FAIL abort_writes: got %0d writes required 1", obs_q.size());
    end
    m_csr[12'h341] = 32'h1234;
    obs_q.delete();
    exp_q.delete();
    rst_n = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL abort_release: req_ready=%b required 1", req_ready);
    end
    run_txn(3'd4, 12'h000, 32'h0, 0, 0, 0, "post_abort_mret", l, t);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall_and_illegal();
    test_back_to_back();
    test_random();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/csr_trap_seq.md
CSR_TRAP_SEQ -- requirements
Module: csr_trap_seq

Interface
REQ-001 Parameter ADDR_WIDTH, default 12, CSR address width.
REQ-002 Parameter DATA_WIDTH, default 32, CSR/data width.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  1  request offered.
REQ-006 req_ready  output  1  request accepted when req_valid&&req_ready at posedge.
REQ-007 req_op  input  3  0 CSRRW, 1 CSRRS, 2 CSRRC, 3 ECALL, 4 MRET, 5-7 illegal.
REQ-008 req_csr  input  ADDR_WIDTH  target CSR address (CSR ops only).
REQ-009 req_src  input  DATA_WIDTH  rs1 value (CSR ops only).
REQ-010 req_pc  input  DATA_WIDTH  pc of trapping instruction (ECALL).
REQ-011 req_cause  input  DATA_WIDTH  mcause value (ECALL).
REQ-012 rsp_valid  output  1  response available.
REQ-013 rsp_ready  input  1  response consumed when rsp_valid&&rsp_ready at posedge.
REQ-014 rsp_rdata  output  DATA_WIDTH  old CSR value (CSR ops), else 0.
REQ-015 rsp_redirect  output  1  1 for ECALL/MRET responses.
REQ-016 rsp_npc  output  DATA_WIDTH  redirect target, valid when rsp_redirect.
REQ-017 rsp_err  output  1  1 for illegal-op responses.
REQ-018 csr_addr  output  ADDR_WIDTH  CSR file address.
REQ-019 csr_wdata  output  DATA_WIDTH  CSR file write data.
REQ-020 csr_wen  output  1  CSR file write enable; write lands at next posedge.
REQ-021 csr_rdata  input  DATA_WIDTH  CSR file combinational read of csr_addr, same cycle; 0 for unmapped.

Function
REQ-022 States SHALL be IDLE, RMW, T_EPC, T_CAUSE, T_STAT, T_VEC, R_STAT, R_EPC, RESP.
REQ-023 req_ready SHALL be 1 only in IDLE; acceptance latches req_op/csr/src/pc/cause; input changes afterwards SHALL be ignored.
REQ-024 Accept: ops 0-2 -> RMW; 3 -> T_EPC; 4 -> R_STAT; 5-7 -> RESP with rsp_err=1, no CSR write.
REQ-025 RMW: csr_addr=req_csr; capture csr_rdata as rsp_rdata; wdata = src (RW), rdata|src (RS), rdata&~src (RC); csr_wen=1 except RS/RC with src==0 (wen=0); -> RESP.
REQ-026 T_EPC: addr 0x341, wdata=req_pc, wen=1 -> T_CAUSE.
REQ-027 T_CAUSE: addr 0x342, wdata=req_cause, wen=1 -> T_STAT.
REQ-028 T_STAT: addr 0x300, wdata=rdata with bit7=rdata[3], bit3=0, bits[12:11]=2'b11, others unchanged, wen=1 -> T_VEC.
REQ-029 T_VEC: addr 0x305, wen=0; rsp_npc=rdata & ~3 (direct mode only), rsp_redirect=1 -> RESP.
REQ-030 R_STAT: addr 0x300, wdata=rdata with bit3=rdata[7], bit7=1, bits[12:11]=0, wen=1 -> R_EPC.
REQ-031 R_EPC: addr 0x341, wen=0; rsp_npc=rdata, rsp_redirect=1 -> RESP.
REQ-032 RESP: rsp_valid=1; rsp_* held stable until rsp_ready; on handshake -> IDLE, rsp_* cleared to 0.
REQ-033 Outside RMW/T_*/R_* states csr_addr, csr_wdata, csr_wen SHALL be 0.
REQ-034 Latency accept->rsp_valid: CSR ops 2 cycles, ECALL 5, MRET 3, illegal 1; throughput max one request per (latency+1) cycles.
REQ-035 No back-pressure on CSR port; one CSR access per cycle, never two.
REQ-036 Arithmetic modulo 2^DATA_WIDTH; no width extension.

Reset
REQ-037 rst_n low SHALL immediately force IDLE and all outputs 0 (req_ready=1 once rst_n high), independent of clk.
REQ-038 Reset mid-sequence SHALL abort without rollback; CSR writes already committed remain.
REQ-039 First acceptance possible at the first posedge with rst_n high.

Verification
REQ-040 CSRRS csr 0x300 src 0x8, mstatus=0x0 -> 1 write 0x8, rsp_rdata=0x0, rsp_valid 2 cycles after accept.
REQ-041 CSRRC src 0 on 0x305 -> csr_wen never asserted, rsp_rdata=old mtvec.
REQ-042 ECALL pc 0x80000010 cause 11, mstatus 0x8, mtvec 0x80000101 -> mepc=0x80000010, mcause=11, mstatus=0x1880, rsp_npc=0x80000100, rsp_redirect=1 after 5 cycles.
REQ-043 MRET with mstatus 0x1880, mepc 0x80000014 -> mstatus=0x88, rsp_npc=0x80000014.
REQ-044 rsp_ready held 0 for 4 cycles -> rsp_* stable, req_ready 0; op 6 -> rsp_err=1, no write.
REQ-045 rst_n low during T_CAUSE -> outputs 0 asynchronously; mepc updated, mcause unchanged.
